// File: rtl/cpu_cfg_slave_pkg.sv
// Shared types and address constants for the CPU configuration slave.
// The cell configuration record, bus FSM states and register offsets live here.
package cpu_cfg_slave_pkg;

  localparam int CFG_NUM_TX = 4;
  localparam int VPI_W      = 12;

  // CTRL and ID sit at the very top of the CPU address space, counted down from all-ones.
  localparam int CTRL_OFFSET = 0;
  localparam int ID_OFFSET   = 1;

  typedef struct packed {
    logic [CFG_NUM_TX-1:0] FWD;
    logic [VPI_W-1:0]      VPI;
  } CellCfgType;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    RELEASE
  } BusStateType;

endpackage

// File: rtl/cpu_cfg_slave_if.sv
// CPU bus and cell-side lookup signals of the configuration slave.
// The master modport is the CPU/cell side; the slave modport is the slave.
interface cpu_cfg_slave_if import cpu_cfg_slave_pkg::*; #(
  parameter int ADDR_W = 12
);

  logic              BusMode;
  logic              Sel;
  logic              Rd_DS;
  logic              Wr_RW;
  logic [ADDR_W-1:0] Addr;
  CellCfgType        DataIn;
  CellCfgType        DataOut;
  logic              Rdy_Dtack;

  logic              lkp_req;
  logic [VPI_W-1:0]  lkp_vpi;
  logic              lkp_vld;
  CellCfgType        lkp_cfg;

  modport master (
    output BusMode, Sel, Rd_DS, Wr_RW, Addr, DataIn, lkp_req, lkp_vpi,
    input  DataOut, Rdy_Dtack, lkp_vld, lkp_cfg
  );

  modport slave (
    input  BusMode, Sel, Rd_DS, Wr_RW, Addr, DataIn, lkp_req, lkp_vpi,
    output DataOut, Rdy_Dtack, lkp_vld, lkp_cfg
  );

endinterface

// File: rtl/cpu_cfg_slave_cfg_table.sv
// Configuration table: one write port and two registered read ports (CPU and lookup).
// A read on the same edge as a write to the same entry returns the old contents.
module cfg_table import cpu_cfg_slave_pkg::*; #(
  parameter  int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  CellCfgType       wrData,
  input  logic             cpuRdEn,
  input  logic [IDX_W-1:0] cpuRdIdx,
  output CellCfgType       cpuRdData,
  input  logic             lkpRdEn,
  input  logic [IDX_W-1:0] lkpRdIdx,
  output CellCfgType       lkpRdData
);

  CellCfgType mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[wrIdx] <= wrData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpuRdData <= '0;
      lkpRdData <= '0;
    end else begin
      if (cpuRdEn) begin
        cpuRdData <= mem[cpuRdIdx];
      end
      if (lkpRdEn) begin
        lkpRdData <= mem[lkpRdIdx];
      end
    end
  end

endmodule

// File: rtl/cpu_cfg_slave.sv
// CPU configuration slave: Intel/Motorola bus front end with wait states, CTRL/ID
// registers and a configuration table that the cell side can look up every cycle.
module cpu_cfg_slave import cpu_cfg_slave_pkg::*; #(
  parameter int          NUM_TX      = 4,
  parameter int          DEPTH       = 256,
  parameter int          ADDR_W      = 12,
  parameter int          WAIT_STATES = 1,
  parameter logic [11:0] VERSION     = 12'h001
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_cfg_slave_if.slave    bus,
  output logic [NUM_TX-1:0] tx_en
);

  localparam int                IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = '1 - ADDR_W'(CTRL_OFFSET);
  localparam logic [ADDR_W-1:0] ID_ADDR   = '1 - ADDR_W'(ID_OFFSET);
  // WAIT_STATES of 0 and 1 both spend exactly one cycle in WAIT.
  localparam logic [3:0]        WAIT_LAST = (WAIT_STATES > 1) ? 4'(WAIT_STATES - 1) : 4'd0;

  BusStateType       state, nextState;
  logic [3:0]        waitCnt;
  logic              busModeLat, isReadLat;
  logic [ADDR_W-1:0] addrLat;
  CellCfgType        dataLat;
  logic              strobeLive, strobeLat, isReadLive;
  logic              goWait, goAck, ack;
  logic              hitCtrl, hitId, hitTable;
  logic              rdFromTable, lkpVld;
  CellCfgType        auxData, auxNext, tblRdData, lkpRdData;
  logic [NUM_TX-1:0] txEn;

  // Intel with both strobes low counts as a write because Wr_RW low wins the direction.
  assign strobeLive = !bus.Sel && (bus.BusMode ? (!bus.Rd_DS || !bus.Wr_RW) : !bus.Rd_DS);
  assign strobeLat  = !bus.Sel && (busModeLat  ? (!bus.Rd_DS || !bus.Wr_RW) : !bus.Rd_DS);
  assign isReadLive = bus.BusMode ? (!bus.Rd_DS && bus.Wr_RW) : bus.Wr_RW;

  assign hitCtrl  = (addrLat == CTRL_ADDR);
  assign hitId    = (addrLat == ID_ADDR);
  assign hitTable = !hitCtrl && !hitId && ((addrLat >> IDX_W) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    goWait    = 1'b0;
    goAck     = 1'b0;
    case (state)
      IDLE: begin
        if (strobeLive) begin
          nextState = WAIT;
          goWait    = 1'b1;
        end
      end
      WAIT: begin
        if (!strobeLat) begin
          nextState = IDLE;
        end else if (waitCnt == WAIT_LAST) begin
          nextState = ACK;
          goAck     = 1'b1;
        end
      end
      ACK: begin
        if (!strobeLat) begin
          nextState = RELEASE;
        end
      end
      RELEASE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    auxNext = '0;
    if (hitCtrl) begin
      auxNext.FWD = CFG_NUM_TX'(txEn);
    end else if (hitId) begin
      auxNext.VPI = VERSION;
    end
  end

  // Transaction latches, wait counter, CTRL register and the read-data source chosen at ACK entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt     <= '0;
      busModeLat  <= 1'b0;
      isReadLat   <= 1'b0;
      addrLat     <= '0;
      dataLat     <= '0;
      txEn        <= '0;
      rdFromTable <= 1'b0;
      auxData     <= '0;
      lkpVld      <= 1'b0;
    end else begin
      if (goWait) begin
        busModeLat <= bus.BusMode;
        isReadLat  <= isReadLive;
        addrLat    <= bus.Addr;
        dataLat    <= bus.DataIn;
        waitCnt    <= '0;
      end else if (state == WAIT) begin
        waitCnt <= waitCnt + 4'd1;
      end
      if (goAck) begin
        rdFromTable <= isReadLat && hitTable;
        auxData     <= isReadLat ? auxNext : '0;
        if (!isReadLat && hitCtrl) begin
          txEn <= NUM_TX'(dataLat.FWD);
        end
      end
      lkpVld <= bus.lkp_req;
    end
  end

  cfg_table #(.DEPTH(DEPTH)) uTable (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrEn      (goAck && !isReadLat && hitTable),
    .wrIdx     (addrLat[IDX_W-1:0]),
    .wrData    (dataLat),
    .cpuRdEn   (goAck && isReadLat && hitTable),
    .cpuRdIdx  (addrLat[IDX_W-1:0]),
    .cpuRdData (tblRdData),
    .lkpRdEn   (bus.lkp_req),
    .lkpRdIdx  (bus.lkp_vpi[IDX_W-1:0]),
    .lkpRdData (lkpRdData)
  );

  assign ack           = (state == ACK);
  assign bus.DataOut   = !ack ? '0 : (rdFromTable ? tblRdData : auxData);
  assign bus.Rdy_Dtack = ((state == IDLE) ? bus.BusMode : busModeLat) ? ack : !ack;
  assign bus.lkp_vld   = lkpVld;
  assign bus.lkp_cfg   = lkpRdData;
  assign tx_en         = txEn;

endmodule

// File: tb/tb_cpu_cfg_slave.sv
// Self-checking bench for cpu_cfg_slave: table-driven bus transactions with a read-data
// scoreboard, plus hand-written lookup collision, abort, wait-state and reset sequences.
module tb_cpu_cfg_slave;
  import cpu_cfg_slave_pkg::*;

  typedef struct {
    int          mode;
    bit          write;
    logic [11:0] addr;
    CellCfgType  wdata;
    CellCfgType  expRd;
    logic [3:0]  expTxEn;
  } VecType;

  typedef struct {
    logic [11:0] vpi;
    CellCfgType  exp;
  } LkpType;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] txEn, txEn3;
  int         checkCount = 0;
  int         passCount  = 0;
  CellCfgType rdExpQ[$];
  CellCfgType lkpExpQ[$];
  VecType     vecs[$];
  LkpType     lkps[$];

  cpu_cfg_slave_if #(.ADDR_W(12)) bus ();
  cpu_cfg_slave_if #(.ADDR_W(12)) bus3 ();

  always #5 clk = ~clk;

  cpu_cfg_slave #(.NUM_TX(4), .DEPTH(256), .ADDR_W(12), .WAIT_STATES(1), .VERSION(12'h001)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .tx_en (txEn)
  );

  // Second slave with three wait states shadows the same CPU bus.
  cpu_cfg_slave #(.NUM_TX(4), .DEPTH(256), .ADDR_W(12), .WAIT_STATES(3), .VERSION(12'h001)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3),
    .tx_en (txEn3)
  );

  assign bus3.BusMode = bus.BusMode;
  assign bus3.Sel     = bus.Sel;
  assign bus3.Rd_DS   = bus.Rd_DS;
  assign bus3.Wr_RW   = bus.Wr_RW;
  assign bus3.Addr    = bus.Addr;
  assign bus3.DataIn  = bus.DataIn;
  assign bus3.lkp_req = 1'b0;
  assign bus3.lkp_vpi = 12'h000;

  function automatic VecType mkVec(input int mode, input bit write, input logic [11:0] addr,
                                   input CellCfgType wdata, input CellCfgType expRd,
                                   input logic [3:0] expTxEn);
    VecType v;
    v.mode    = mode;
    v.write   = write;
    v.addr    = addr;
    v.wdata   = wdata;
    v.expRd   = expRd;
    v.expTxEn = expTxEn;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got === want) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic busIdle();
    bus.Sel   = 1'b1;
    bus.Rd_DS = 1'b1;
    bus.Wr_RW = 1'b1;
  endtask

  // mode 0 = Intel, 1 = Motorola, 2 = Intel with both strobes low
  task automatic applyStimulus(input int mode, input bit write, input logic [11:0] addr,
                               input CellCfgType wdata, input string tag);
    int         lat;
    bit         intel;
    CellCfgType exp;
    intel       = (mode != 1);
    bus.BusMode = intel;
    bus.Addr    = addr;
    bus.DataIn  = wdata;
    bus.Sel     = 1'b0;
    if (mode == 1) begin
      bus.Wr_RW = !write;
      bus.Rd_DS = 1'b0;
    end else if (mode == 2) begin
      bus.Rd_DS = 1'b0;
      bus.Wr_RW = 1'b0;
    end else begin
      bus.Rd_DS = write;
      bus.Wr_RW = !write;
    end
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.Rdy_Dtack === intel) break;
    end
    checkOutput($sformatf("%s latency", tag), 32'(lat), 32'd2);
    checkOutput($sformatf("%s ack level", tag), 32'(bus.Rdy_Dtack), 32'(intel));
    if (!write) begin
      exp = rdExpQ.pop_front();
      checkOutput($sformatf("%s read data", tag), 32'(bus.DataOut), 32'(exp));
    end
    busIdle();
    @(posedge clk); #1;
    checkOutput($sformatf("%s release level", tag), 32'(bus.Rdy_Dtack), 32'(!intel));
    checkOutput($sformatf("%s release data", tag), 32'(bus.DataOut), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int  lat, lat3;
    bit  sawAck;

    vecs.push_back(mkVec(0, 1, 12'h005, {4'hA, 12'h123}, '0, 4'h0));
    vecs.push_back(mkVec(0, 0, 12'h005, '0, {4'hA, 12'h123}, 4'h0));
    vecs.push_back(mkVec(1, 0, 12'hFFE, '0, {4'h0, 12'h001}, 4'h0));
    vecs.push_back(mkVec(0, 1, 12'hFFF, {4'h6, 12'h3FF}, '0, 4'h6));
    vecs.push_back(mkVec(0, 0, 12'hFFF, '0, {4'h6, 12'h000}, 4'h6));
    vecs.push_back(mkVec(0, 0, 12'h800, '0, '0, 4'h6));
    vecs.push_back(mkVec(0, 1, 12'h800, {4'hF, 12'hFFF}, '0, 4'h6));
    vecs.push_back(mkVec(1, 1, 12'h0FF, {4'h3, 12'hABC}, '0, 4'h6));
    vecs.push_back(mkVec(1, 0, 12'h0FF, '0, {4'h3, 12'hABC}, 4'h6));
    vecs.push_back(mkVec(0, 0, 12'h100, '0, '0, 4'h6));
    vecs.push_back(mkVec(0, 1, 12'h100, {4'hF, 12'h555}, '0, 4'h6));
    vecs.push_back(mkVec(0, 0, 12'h000, '0, '0, 4'h6));
    vecs.push_back(mkVec(1, 1, 12'hFFE, {4'hF, 12'hFFF}, '0, 4'h6));
    vecs.push_back(mkVec(1, 0, 12'hFFE, '0, {4'h0, 12'h001}, 4'h6));
    vecs.push_back(mkVec(2, 1, 12'h007, {4'h5, 12'h777}, '0, 4'h6));
    vecs.push_back(mkVec(1, 0, 12'h007, '0, {4'h5, 12'h777}, 4'h6));
    vecs.push_back(mkVec(0, 0, 12'h005, '0, {4'hA, 12'h123}, 4'h6));
    vecs.push_back(mkVec(1, 1, 12'hFFF, {4'h9, 12'h000}, '0, 4'h9));
    vecs.push_back(mkVec(1, 0, 12'hFFF, '0, {4'h9, 12'h000}, 4'h9));

    rst_n       = 1'b0;
    bus.BusMode = 1'b0;
    bus.Addr    = '0;
    bus.DataIn  = '0;
    bus.lkp_req = 1'b0;
    bus.lkp_vpi = '0;
    busIdle();
    #1;
    checkOutput("reset dtack motorola", 32'(bus.Rdy_Dtack), 32'd1);
    bus.BusMode = 1'b1;
    #1;
    checkOutput("reset ready intel", 32'(bus.Rdy_Dtack), 32'd0);
    checkOutput("reset DataOut", 32'(bus.DataOut), 32'd0);
    checkOutput("reset tx_en", 32'(txEn), 32'd0);
    checkOutput("reset lkp_vld", 32'(bus.lkp_vld), 32'd0);
    checkOutput("reset lkp_cfg", 32'(bus.lkp_cfg), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] running %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      if (!vecs[i].write) rdExpQ.push_back(vecs[i].expRd);
      applyStimulus(vecs[i].mode, vecs[i].write, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d tx_en", i), 32'(txEn), 32'(vecs[i].expTxEn));
    end

    // Lookup samples entry 5 on the same edge the CPU write to entry 5 commits.
    bus.BusMode = 1'b1;
    bus.Addr    = 12'h005;
    bus.DataIn  = {4'hC, 12'h456};
    bus.Sel     = 1'b0;
    bus.Rd_DS   = 1'b1;
    bus.Wr_RW   = 1'b0;
    @(posedge clk); #1;
    bus.lkp_req = 1'b1;
    bus.lkp_vpi = 12'h105;
    lkpExpQ.push_back({4'hA, 12'h123});
    @(posedge clk); #1;
    bus.lkp_req = 1'b0;
    checkOutput("collision ack", 32'(bus.Rdy_Dtack), 32'd1);
    checkOutput("collision lkp_vld", 32'(bus.lkp_vld), 32'd1);
    checkOutput("collision old data", 32'(bus.lkp_cfg), 32'(lkpExpQ.pop_front()));
    busIdle();
    @(posedge clk); #1;
    checkOutput("lkp_vld idle", 32'(bus.lkp_vld), 32'd0);
    checkOutput("lkp_cfg hold", 32'(bus.lkp_cfg), 32'(CellCfgType'({4'hA, 12'h123})));
    @(posedge clk); #1;

    lkps.push_back('{12'h105, {4'hC, 12'h456}});
    lkps.push_back('{12'h0FF, {4'h3, 12'hABC}});
    lkps.push_back('{12'hE07, {4'h5, 12'h777}});
    lkps.push_back('{12'h042, '0});
    for (int i = 0; i < lkps.size(); i++) begin
      bus.lkp_req = 1'b1;
      bus.lkp_vpi = lkps[i].vpi;
      lkpExpQ.push_back(lkps[i].exp);
      @(posedge clk); #1;
      bus.lkp_req = 1'b0;
      checkOutput($sformatf("lookup%0d vld", i), 32'(bus.lkp_vld), 32'd1);
      checkOutput($sformatf("lookup%0d cfg", i), 32'(bus.lkp_cfg), 32'(lkpExpQ.pop_front()));
    end
    @(posedge clk); #1;

    // Write to entry 9 whose strobe is withdrawn while still in WAIT.
    bus.BusMode = 1'b1;
    bus.Addr    = 12'h009;
    bus.DataIn  = {4'hF, 12'h999};
    bus.Sel     = 1'b0;
    bus.Rd_DS   = 1'b1;
    bus.Wr_RW   = 1'b0;
    @(posedge clk); #1;
    busIdle();
    sawAck = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.Rdy_Dtack !== 1'b0) sawAck = 1'b1;
    end
    checkOutput("abort no ack", 32'(sawAck), 32'd0);
    rdExpQ.push_back('0);
    applyStimulus(0, 0, 12'h009, '0, "abort readback");

    // Held ID read: both slaves acknowledge after their own wait-state counts.
    bus.BusMode = 1'b1;
    bus.Addr    = 12'hFFE;
    bus.Sel     = 1'b0;
    bus.Rd_DS   = 1'b0;
    bus.Wr_RW   = 1'b1;
    lat  = 0;
    lat3 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (lat == 0 && bus.Rdy_Dtack === 1'b1) lat = c;
      if (lat3 == 0 && bus3.Rdy_Dtack === 1'b1) lat3 = c;
    end
    checkOutput("ws1 latency", 32'(lat), 32'd2);
    checkOutput("ws3 latency", 32'(lat3), 32'd4);
    checkOutput("ws3 ID data", 32'(bus3.DataOut), 32'(CellCfgType'({4'h0, 12'h001})));
    busIdle();
    repeat (2) @(posedge clk);
    #1;

    // Reset arrives mid-cycle while a read of entry 5 is being acknowledged.
    bus.lkp_req = 1'b1;
    bus.lkp_vpi = 12'h005;
    bus.Addr    = 12'h005;
    bus.Sel     = 1'b0;
    bus.Rd_DS   = 1'b0;
    bus.Wr_RW   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.lkp_req = 1'b0;
    checkOutput("pre-reset ack", 32'(bus.Rdy_Dtack), 32'd1);
    checkOutput("pre-reset data", 32'(bus.DataOut), 32'(CellCfgType'({4'hC, 12'h456})));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset ack", 32'(bus.Rdy_Dtack), 32'd0);
    checkOutput("async reset data", 32'(bus.DataOut), 32'd0);
    checkOutput("async reset tx_en", 32'(txEn), 32'd0);
    checkOutput("async reset lkp_vld", 32'(bus.lkp_vld), 32'd0);
    checkOutput("async reset lkp_cfg", 32'(bus.lkp_cfg), 32'd0);
    busIdle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdExpQ.push_back('0);
    applyStimulus(0, 0, 12'h005, '0, "post-reset entry5");
    rdExpQ.push_back('0);
    applyStimulus(1, 0, 12'hFFF, '0, "post-reset CTRL");
    rdExpQ.push_back('0);
    applyStimulus(0, 0, 12'h0FF, '0, "post-reset entry255");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
